parking_lot_counter: RTL and testbench
======================================

// Module: parking_lot_counter
// PURPOSE
//  Multi-lane occupancy counter for the parking-lot controller. Each lane has two active-low
//  optical sensors (a = outer, b = inner). After synchronisation and debounce, a per-lane FSM
//  decodes the full a/b blocking sequence into entry or exit events. A saturating occupancy
//  counter with full/empty flags and reject pulses aggregates all lanes.
// PARAMETERS
//  N_LANES   2   number of independent entry/exit lanes (>=1)
//  CAPACITY  7   maximum occupancy; the count saturates here (>=1)
//  COUNT_W   3   count width; must satisfy 2**COUNT_W > CAPACITY
//  DEBOUNCE  4   cycles a synchronised sensor level must hold before it is accepted (>=1)
// PORTS
//  clk        in   1        system clock; all state updates on the rising edge
//  reset      in   1        asynchronous, active-low reset
//  sensor_a   in   N_LANES  outer beam per lane; 0 = blocked, asynchronous to clk
//  sensor_b   in   N_LANES  inner beam per lane; 0 = blocked, asynchronous to clk
//  count      out  COUNT_W  current occupancy, registered
//  full       out  1        count == CAPACITY, registered
//  empty      out  1        count == 0, registered
//  entry_evt  out  N_LANES  one-cycle pulse per lane on a completed entry
//  exit_evt   out  N_LANES  one-cycle pulse per lane on a completed exit
//  reject     out  1        one-cycle pulse: an event was clipped by saturation
// BEHAVIOUR
//  Reset (reset=0, asynchronous): count=0, empty=1, full=0, all pulses=0, FSMs=IDLE.
//   Synchroniser flops preset to 1 and filtered sensors preset to clear. Asserting reset
//   mid-sequence aborts that sequence; no event is produced.
//  Input path per sensor: 2-flop synchroniser, then debounce. The filtered level takes the
//   new value once the synchronised value has differed from it for DEBOUNCE consecutive
//   cycles. Shorter glitches are ignored.
//  Per-lane FSM on filtered A = a blocked, B = b blocked; one transition per cycle:
//   IDLE:   A&!B -> IN_A; !A&B -> OUT_B; otherwise stay (A&B from IDLE is ignored).
//   IN_A:   A&B -> IN_AB;  !A&!B -> IDLE (abort);  else stay.
//   IN_AB:  !A&B -> IN_B;  A&!B -> IN_A (backing out);  !A&!B -> IDLE (abort).
//   IN_B:   !A&!B -> IDLE + entry_evt;  A&B -> IN_AB;  A&!B -> IDLE (abort).
//   OUT_B/OUT_BA/OUT_A mirror IN_A/IN_AB/IN_B with a and b swapped; the final clear gives exit_evt.
//  Event latency: entry_evt/exit_evt are asserted in the cycle after the filtered sensors
//   both read clear. count/full/empty update one cycle after the event pulse.
//  Counter arithmetic: E = popcount(entry_evt), X = popcount(exit_evt), all lanes in the same
//   cycle. next = count + E - X, computed signed at width COUNT_W+$clog2(N_LANES)+2.
//   Result is clamped to [0, CAPACITY].
//  reject pulses in the same cycle as the count update when clamping altered the result.
//   Example: at count=CAPACITY with E=1, X=0, count stays and reject=1.
//  Simultaneous entry and exit (same lane impossible; different lanes) net out: at
//   count=CAPACITY with E=1, X=1, count is unchanged and reject=0.
//  full and empty are derived from the registered count and are never both 1.
// TESTING
//  1 Lane0 a,b = 01,00,10,11 (active-low, each held 2*DEBOUNCE cycles) from count=0
//    -> entry_evt[0] pulses once; count=1, empty=0.
//  2 Lane0 a,b = 10,00,01,11 at count=1 -> exit_evt[0] pulses; count=0, empty=1.
//  3 Lane0 a,b = 01,00,01,11 (backs out) -> no event; count unchanged.
//    A 2-cycle glitch on sensor_a with DEBOUNCE=4 -> FSM stays IDLE.
//  4 Eight entries with CAPACITY=7 -> count=7, full=1 after the 7th entry;
//    the 8th entry gives reject=1 and count stays 7.
//  5 At count=0, an exit -> reject=1 and count=0.
//    Lane0 entry and lane1 exit completing in the same cycle at count=7 -> count=7, reject=0.
//  6 Drop reset low mid-sequence (lane0 in IN_AB, count=3), then release -> count=0, no event.
//    A fresh entry afterwards -> count=1.

Source files
------------

// File: rtl/parking_lot_counter.sv
// parking_lot_counter
//   Multi-lane parking-lot occupancy counter. Each lane has two active-low
//   optical beams (a = outer, b = inner). Every beam is synchronised and
//   debounced, then a per-lane FSM decodes the full blocking sequence into
//   entry / exit pulses. All lane pulses are summed into one saturating count.
//
// Ports
//   clk        in   1        system clock, rising edge
//   reset      in   1        asynchronous, active-low reset
//   sensor_a   in   N_LANES  outer beam per lane, 0 = blocked, async to clk
//   sensor_b   in   N_LANES  inner beam per lane, 0 = blocked, async to clk
//   count      out  COUNT_W  registered occupancy, clamped to [0, CAPACITY]
//   full       out  1        registered, count == CAPACITY
//   empty      out  1        registered, count == 0
//   entry_evt  out  N_LANES  one-cycle pulse per lane on a completed entry
//   exit_evt   out  N_LANES  one-cycle pulse per lane on a completed exit
//   reject     out  1        one-cycle pulse when saturation clipped the update
//
// COUNT_W must satisfy 2**COUNT_W > CAPACITY.

// ---------------------------------------------------------------------------
// plc_debounce
//   2-flop synchroniser followed by a level filter. The filtered output only
//   follows the synchronised input after it has differed for DEBOUNCE
//   consecutive cycles; anything shorter is dropped.
//
// Ports
//   clk    in   1  system clock
//   reset  in   1  asynchronous, active-low reset
//   din    in   1  raw active-low beam, async to clk
//   dout   out  1  filtered active-low beam (1 = clear)
// ---------------------------------------------------------------------------
module plc_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Preset to 1 so a beam reads "clear" straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], din};
    end

    // cnt holds how many consecutive cycles sync[1] has disagreed with dout,
    // minus one; the update lands on the DEBOUNCE-th disagreeing cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= 1'b1;
            cnt  <= '0;
        end else if (sync[1] == dout) begin
            cnt  <= '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
            dout <= sync[1];
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// plc_lane
//   One entry/exit lane: two filtered beams and the direction-decoding FSM.
//   A vehicle must block a, then a+b, then only b, then clear (entry), or the
//   mirror image (exit). Any early clear aborts silently; reversing into the
//   previous step is allowed.
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-low reset
//   sensor_a   in   1  raw outer beam, 0 = blocked
//   sensor_b   in   1  raw inner beam, 0 = blocked
//   entry_evt  out  1  registered one-cycle entry pulse
//   exit_evt   out  1  registered one-cycle exit pulse
// ---------------------------------------------------------------------------
module plc_lane #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic entry_evt,
    output logic exit_evt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN_A   = 3'd1,
        IN_AB  = 3'd2,
        IN_B   = 3'd3,
        OUT_B  = 3'd4,
        OUT_BA = 3'd5,
        OUT_A  = 3'd6
    } lane_st_e;

    logic     filt_a, filt_b;
    logic     blk_a, blk_b;
    lane_st_e st, st_nxt;
    logic     entry_nxt, exit_nxt;

    plc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .din   (sensor_a),
        .dout  (filt_a)
    );

    plc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .din   (sensor_b),
        .dout  (filt_b)
    );

    assign blk_a = ~filt_a;
    assign blk_b = ~filt_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            entry_evt <= 1'b0;
            exit_evt  <= 1'b0;
        end else begin
            st        <= st_nxt;
            entry_evt <= entry_nxt;
            exit_evt  <= exit_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        entry_nxt = 1'b0;
        exit_nxt  = 1'b0;
        case (st)
            // Both beams blocked from idle has no direction; wait it out.
            IDLE: begin
                if (blk_a && !blk_b)      st_nxt = IN_A;
                else if (!blk_a && blk_b) st_nxt = OUT_B;
            end
            IN_A: begin
                if (blk_a && blk_b)        st_nxt = IN_AB;
                else if (!blk_a && !blk_b) st_nxt = IDLE;
            end
            IN_AB: begin
                if (!blk_a && blk_b)       st_nxt = IN_B;
                else if (blk_a && !blk_b)  st_nxt = IN_A;
                else if (!blk_a && !blk_b) st_nxt = IDLE;
            end
            IN_B: begin
                if (!blk_a && !blk_b) begin
                    st_nxt    = IDLE;
                    entry_nxt = 1'b1;
                end else if (blk_a && blk_b) begin
                    st_nxt = IN_AB;
                end else if (blk_a && !blk_b) begin
                    st_nxt = IDLE;
                end
            end
            OUT_B: begin
                if (blk_a && blk_b)        st_nxt = OUT_BA;
                else if (!blk_a && !blk_b) st_nxt = IDLE;
            end
            OUT_BA: begin
                if (blk_a && !blk_b)       st_nxt = OUT_A;
                else if (!blk_a && blk_b)  st_nxt = OUT_B;
                else if (!blk_a && !blk_b) st_nxt = IDLE;
            end
            OUT_A: begin
                if (!blk_a && !blk_b) begin
                    st_nxt   = IDLE;
                    exit_nxt = 1'b1;
                end else if (blk_a && blk_b) begin
                    st_nxt = OUT_BA;
                end else if (!blk_a && blk_b) begin
                    st_nxt = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// parking_lot_counter (top)
// ---------------------------------------------------------------------------
module parking_lot_counter #(
    parameter int N_LANES  = 2,
    parameter int CAPACITY = 7,
    parameter int COUNT_W  = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] sensor_a,
    input  logic [N_LANES-1:0] sensor_b,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic [N_LANES-1:0] entry_evt,
    output logic [N_LANES-1:0] exit_evt,
    output logic               reject
);
    // Wide enough for count + N_LANES entries and for going negative.
    localparam int SW = COUNT_W + $clog2(N_LANES) + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic        [SW-1:0]      n_entry, n_exit;
    logic signed [SW-1:0]      sum;
    logic        [COUNT_W-1:0] count_nxt;
    logic                      clip;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        plc_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .sensor_a  (sensor_a[i]),
            .sensor_b  (sensor_b[i]),
            .entry_evt (entry_evt[i]),
            .exit_evt  (exit_evt[i])
        );
    end

    // All lanes are netted in one step, so an entry and an exit finishing in
    // the same cycle cancel before saturation is considered.
    always_comb begin
        n_entry = '0;
        n_exit  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            n_entry = n_entry + SW'(entry_evt[i]);
            n_exit  = n_exit  + SW'(exit_evt[i]);
        end
        sum       = $signed(SW'(count)) + $signed(n_entry) - $signed(n_exit);
        count_nxt = sum[COUNT_W-1:0];
        clip      = 1'b0;
        if (sum[SW-1]) begin
            count_nxt = '0;
            clip      = 1'b1;
        end else if (sum > CAP_S) begin
            count_nxt = COUNT_W'(CAPACITY);
            clip      = 1'b1;
        end
    end

    // full/empty are registered from the same next value as count so all
    // three change together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            reject <= 1'b0;
        end else begin
            count  <= count_nxt;
            full   <= (count_nxt == COUNT_W'(CAPACITY));
            empty  <= (count_nxt == '0);
            reject <= clip;
        end
    end
endmodule

// File: tb/tb_parking_lot_counter.sv
module tb_parking_lot_counter;
    localparam int N_LANES  = 2;
    localparam int CAPACITY = 7;
    localparam int COUNT_W  = 3;
    localparam int DEBOUNCE = 4;
    localparam int HOLD     = 2 * DEBOUNCE;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_LANES-1:0] sensor_a;
    logic [N_LANES-1:0] sensor_b;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic               empty;
    logic [N_LANES-1:0] entry_evt;
    logic [N_LANES-1:0] exit_evt;
    logic               reject;

    int checks = 0;
    int errors = 0;

    // Pulse-cycle tallies, sampled on the falling edge.
    int ent0 = 0, ent1 = 0, ext0 = 0, ext1 = 0, rej = 0, busy0 = 0;
    int s_ent0, s_ent1, s_ext0, s_ext1, s_rej, s_busy0;

    parking_lot_counter #(
        .N_LANES  (N_LANES),
        .CAPACITY (CAPACITY),
        .COUNT_W  (COUNT_W),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .entry_evt (entry_evt),
        .exit_evt  (exit_evt),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ent0 <= ent0 + int'(entry_evt[0]);
        ent1 <= ent1 + int'(entry_evt[1]);
        ext0 <= ext0 + int'(exit_evt[0]);
        ext1 <= ext1 + int'(exit_evt[1]);
        rej  <= rej  + int'(reject);
        if (dut.g_lane[0].u_lane.st != 3'd0) busy0 <= busy0 + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        s_ent0 = ent0; s_ent1 = ent1; s_ext0 = ext0; s_ext1 = ext1;
        s_rej = rej; s_busy0 = busy0;
    endtask

    // ab in "a,b" notation: ab[1] = sensor_a, ab[0] = sensor_b, 0 = blocked.
    task automatic lanes(input logic [1:0] ab0, input logic [1:0] ab1, input int n);
        sensor_a = {ab1[1], ab0[1]};
        sensor_b = {ab1[0], ab0[0]};
        wait_cyc(n);
    endtask

    task automatic entry0();
        lanes(2'b01, 2'b11, HOLD);
        lanes(2'b00, 2'b11, HOLD);
        lanes(2'b10, 2'b11, HOLD);
        lanes(2'b11, 2'b11, 2 * HOLD);
    endtask

    task automatic exit0();
        lanes(2'b10, 2'b11, HOLD);
        lanes(2'b00, 2'b11, HOLD);
        lanes(2'b01, 2'b11, HOLD);
        lanes(2'b11, 2'b11, 2 * HOLD);
    endtask

    initial begin
        reset    = 1'b0;
        sensor_a = '1;
        sensor_b = '1;
        wait_cyc(3);

        // Reset state
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_evts", int'({entry_evt, exit_evt}), 0);
        reset = 1'b1;
        wait_cyc(4);

        // 1: entry on lane 0
        snap();
        entry0();
        check("t1_entry_pulse", ent0 - s_ent0, 1);
        check("t1_no_exit", ext0 - s_ext0, 0);
        check("t1_count", int'(count), 1);
        check("t1_empty", int'(empty), 0);

        // 2: exit on lane 0
        snap();
        exit0();
        check("t2_exit_pulse", ext0 - s_ext0, 1);
        check("t2_count", int'(count), 0);
        check("t2_empty", int'(empty), 1);

        // 3: back out after both beams blocked
        snap();
        lanes(2'b01, 2'b11, HOLD);
        lanes(2'b00, 2'b11, HOLD);
        lanes(2'b01, 2'b11, HOLD);
        lanes(2'b11, 2'b11, 2 * HOLD);
        check("t3_backout_evts", (ent0 - s_ent0) + (ext0 - s_ext0), 0);
        check("t3_count", int'(count), 0);

        // 3b: 2-cycle glitch on a is filtered out
        snap();
        lanes(2'b01, 2'b11, 2);
        lanes(2'b11, 2'b11, 3 * HOLD);
        check("t3_glitch_fsm_idle", busy0 - s_busy0, 0);

        // 5a: exit at count 0 clips
        snap();
        exit0();
        check("t5_underflow_reject", rej - s_rej, 1);
        check("t5_underflow_count", int'(count), 0);
        check("t5_underflow_empty", int'(empty), 1);

        // 4: fill to capacity, then one more
        snap();
        for (int k = 0; k < 7; k++) entry0();
        check("t4_count7", int'(count), 7);
        check("t4_full", int'(full), 1);
        check("t4_no_reject", rej - s_rej, 0);
        snap();
        entry0();
        check("t4_overflow_reject", rej - s_rej, 1);
        check("t4_overflow_count", int'(count), 7);
        check("t4_overflow_full", int'(full), 1);

        // 5b: lane0 entry and lane1 exit finish together at capacity
        snap();
        lanes(2'b01, 2'b10, HOLD);
        lanes(2'b00, 2'b00, HOLD);
        lanes(2'b10, 2'b01, HOLD);
        lanes(2'b11, 2'b11, 2 * HOLD);
        check("t5_sim_entry0", ent0 - s_ent0, 1);
        check("t5_sim_exit1", ext1 - s_ext1, 1);
        check("t5_sim_count", int'(count), 7);
        check("t5_sim_reject", rej - s_rej, 0);

        // 6: down to 3, abort with reset in IN_AB
        for (int k = 0; k < 4; k++) exit0();
        check("t6_count3", int'(count), 3);
        check("t6_full_clear", int'(full), 0);
        snap();
        lanes(2'b01, 2'b11, HOLD);
        lanes(2'b00, 2'b11, HOLD);
        check("t6_in_ab", int'(dut.g_lane[0].u_lane.st), 2);
        reset = 1'b0;
        #2;
        check("t6_async_count", int'(count), 0);
        wait_cyc(2);
        sensor_a = '1;
        sensor_b = '1;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(3 * HOLD);
        check("t6_count0", int'(count), 0);
        check("t6_empty", int'(empty), 1);
        check("t6_no_event", (ent0 - s_ent0) + (ext0 - s_ext0), 0);
        entry0();
        check("t6_fresh_entry", int'(count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
